// File: rtl/r_prog_ramp_if.sv
// r_prog_ramp_if: target handshake, ramp controls and resistor-code outputs
// of the r_prog ramp controller. The master side is the requester, and the
// slave side is the ramp block.
interface r_prog_ramp_if #(
    parameter int DWELL_W = 8
);
    logic [3:0]         tgt_code;
    logic               tgt_valid;
    logic               tgt_ready;
    logic [DWELL_W-1:0] dwell;
    logic               hold;
    logic               abort;
    logic [3:0]         r_prog;
    logic               busy;
    logic               done;

    modport master (
        output tgt_code, tgt_valid, dwell, hold, abort,
        input  tgt_ready, r_prog, busy, done
    );

    modport slave (
        input  tgt_code, tgt_valid, dwell, hold, abort,
        output tgt_ready, r_prog, busy, done
    );
endinterface

// File: rtl/r_prog_ramp.sv
// r_prog_ramp: walks the 4-bit resistor code toward an accepted target one
// code at a time. A programmable dwell separates the steps, so the resistor
// network never sees a multi-code jump. hold freezes the ramp, and abort
// ends it at the current code.
module r_prog_ramp #(
    parameter int         DWELL_W    = 8,
    parameter logic [3:0] RESET_CODE = 4'd0
) (
    input  logic         clk,
    input  logic         rst,
    r_prog_ramp_if.slave bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [3:0]         r_prog_reg, r_prog_next;
    logic [3:0]         tgt_q_reg, tgt_q_next;
    logic [DWELL_W-1:0] dwell_q_reg, dwell_q_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic               done_reg, done_next;
    logic [3:0]         step_code;

    // One code toward the latched target. Because the ramp stops on reaching
    // the target, it can never wrap.
    assign step_code = (tgt_q_reg > r_prog_reg) ? r_prog_reg + 4'd1
                                                : r_prog_reg - 4'd1;

    // Next-state and datapath decisions. In RAMP the checks run in this
    // order: abort, then hold, then dwell countdown, then step.
    always_comb begin
        state_next   = state_reg;
        r_prog_next  = r_prog_reg;
        tgt_q_next   = tgt_q_reg;
        dwell_q_next = dwell_q_reg;
        cnt_next     = cnt_reg;
        done_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.tgt_valid) begin
                    tgt_q_next   = bus.tgt_code;
                    dwell_q_next = bus.dwell;
                    if (bus.tgt_code == r_prog_reg) begin
                        done_next = 1'b1;
                    end else begin
                        cnt_next   = bus.dwell;
                        state_next = ST_RAMP;
                    end
                end
            end
            ST_RAMP: begin
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else if (bus.hold) begin
                    state_next = ST_RAMP;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    r_prog_next = step_code;
                    if (step_code == tgt_q_reg) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = dwell_q_reg;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and datapath registers. An asynchronous reset returns the code
    // to RESET_CODE at once and drops any ramp that is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            r_prog_reg  <= RESET_CODE;
            tgt_q_reg   <= 4'd0;
            dwell_q_reg <= '0;
            cnt_reg     <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            r_prog_reg  <= r_prog_next;
            tgt_q_reg   <= tgt_q_next;
            dwell_q_reg <= dwell_q_next;
            cnt_reg     <= cnt_next;
            done_reg    <= done_next;
        end
    end

    assign bus.r_prog    = r_prog_reg;
    assign bus.done      = done_reg;
    assign bus.busy      = (state_reg == ST_RAMP);
    assign bus.tgt_ready = (state_reg == ST_IDLE);
endmodule

// File: tb/tb_r_prog_ramp.sv
// tb_r_prog_ramp: randomized bench for r_prog_ramp. The reference model
// predicts the code from elapsed timing. Step k of a ramp lands on the edge
// where the number of non-hold ramp cycles since acceptance reaches
// k*(dwell+1). An abort freezes the code wherever it stands.
module tb_r_prog_ramp;
    localparam int DWELL_W = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [3:0] cur;    // model's view of the current resistor code

    r_prog_ramp_if #(.DWELL_W(DWELL_W)) bus ();

    r_prog_ramp #(
        .DWELL_W   (DWELL_W),
        .RESET_CODE(4'd0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // 100 MHz-style free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_state(input string tag);
        chk({tag, ".r_prog"}, bus.r_prog, 32'(cur));
        chk({tag, ".ready"}, bus.tgt_ready, 1);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".done"}, bus.done, 0);
    endtask

    // One transaction from IDLE. hp is the hold probability in percent and
    // ap is the abort probability in per mille, both applied on each ramp
    // cycle. Junk requests and dwell changes are also driven during the ramp
    // and must be ignored.
    task automatic run_txn(input logic [3:0] t, input int d, input int hp, input int ap);
        int   n, dir, act, steps, k, e;
        logic [3:0] s;
        logic [3:0] er;
        bit   fin, h, a, reached;
        s = cur;
        bus.tgt_code  = t;
        bus.dwell     = DWELL_W'(d);
        bus.tgt_valid = 1'b1;
        bus.hold      = 1'b0;
        bus.abort     = 1'b0;
        chk("ready_before_accept", bus.tgt_ready, 1);
        tick();
        bus.tgt_valid = 1'b0;
        $display("txn: from=%0d to=%0d dwell=%0d", s, t, d);
        if (t == s) begin
            chk("eq.r_prog", bus.r_prog, 32'(s));
            chk("eq.done", bus.done, 1);
            chk("eq.busy", bus.busy, 0);
            chk("eq.ready", bus.tgt_ready, 1);
            return;
        end
        dir = (t > s) ? 1 : -1;
        n   = (t > s) ? int'(t) - int'(s) : int'(s) - int'(t);
        chk("acc.busy", bus.busy, 1);
        chk("acc.ready", bus.tgt_ready, 0);
        chk("acc.done", bus.done, 0);
        chk("acc.r_prog", bus.r_prog, 32'(s));
        act = 0;
        fin = 1'b0;
        k   = 0;
        er  = s;
        while (!fin && k < 400) begin
            h = ($urandom_range(99) < hp);
            a = ($urandom_range(999) < ap);
            bus.hold      = h;
            bus.abort     = a;
            bus.tgt_valid = $urandom_range(1);
            bus.tgt_code  = 4'($urandom);
            bus.dwell     = DWELL_W'($urandom);
            tick();
            k++;
            reached = 1'b0;
            if (a) begin
                fin = 1'b1;
            end else if (!h) begin
                act++;
                if (act == n * (d + 1)) begin
                    reached = 1'b1;
                    fin     = 1'b1;
                end
            end
            steps = act / (d + 1);
            e     = int'(s) + dir * steps;
            er    = 4'(e);
            chk("ramp.r_prog", bus.r_prog, 32'(er));
            chk("ramp.done", bus.done, 32'(reached));
            chk("ramp.busy", bus.busy, 32'(!fin));
            chk("ramp.ready", bus.tgt_ready, 32'(fin));
        end
        if (!fin) chk("ramp.timeout", 0, 1);
        cur           = er;
        bus.tgt_valid = 1'b0;
        bus.hold      = 1'b0;
        bus.abort     = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cur   = 4'd0;
        bus.tgt_code  = 4'd0;
        bus.tgt_valid = 1'b0;
        bus.dwell     = '0;
        bus.hold      = 1'b0;
        bus.abort     = 1'b0;
        rst = 1'b1;
        #12;
        chk_idle_state("reset");
        #1 rst = 1'b0;
        tick();
        chk_idle_state("post_reset");

        // Directed cases: ramp up with a dwell, ramp down one step per cycle,
        // an equal target, and a hold/abort-heavy ramp.
        run_txn(4'd3, 2, 0, 0);
        run_txn(4'd15, 0, 0, 0);
        run_txn(4'd13, 0, 0, 0);
        run_txn(4'd5, 1, 0, 0);
        run_txn(4'd5, 3, 0, 0);
        run_txn(4'd0, 0, 0, 0);
        run_txn(4'd8, 1, 40, 60);

        // Reset in the middle of a 0 -> 15 ramp, once the code reads 6.
        run_txn(4'd0, 0, 0, 0);
        bus.tgt_code  = 4'd15;
        bus.dwell     = '0;
        bus.tgt_valid = 1'b1;
        tick();
        bus.tgt_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("mid.r_prog", bus.r_prog, 32'(i));
        end
        #3 rst = 1'b1;
        #1;
        cur = 4'd0;
        $display("txn: async reset at code 6");
        chk_idle_state("async_reset");
        #1 rst = 1'b0;
        run_txn(4'd2, 1, 0, 0);

        // Random transactions, with hold, abort and junk requests mixed in.
        for (int j = 0; j < 40; j++) begin
            run_txn(4'($urandom), int'($urandom_range(3)), 20, 30);
        end
        tick();
        chk("final.done", bus.done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
